mod_counter_ctrl: RTL

MOD_COUNTER_CTRL -- requirements
Module: mod_counter_ctrl

---
 rtl/mod_counter_ctrl.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/mod_counter_ctrl.sv
// Programmable modulo-M counter that runs R full wraps per accepted start, with pause/stop control.
// Latency: start accepted on edge N -> RUN from edge N; done pulses M*R edges later; tc is combinational.
// Backpressure: pause freezes count/rep_cnt in HOLD; stop aborts to IDLE; start is ignored while active.
module mod_counter_ctrl #(
   parameter int MOD_W = 8,
   parameter int REP_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             stop,
   input  logic             pause,
   input  logic [MOD_W-1:0] modulus,
   input  logic [REP_W-1:0] reps,
   output logic [MOD_W-1:0] count,
   output logic [REP_W-1:0] rep_cnt,
   output logic             tc,
   output logic             busy,
   output logic             paused,
   output logic             done,
   output logic             err
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HOLD = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam logic [MOD_W-1:0] MOD_ONE = MOD_W'(1);
   localparam logic [REP_W-1:0] REP_ONE = REP_W'(1);

   state_t           state, state_nx;
   logic [MOD_W-1:0] m_lat, m_nx;
   logic [REP_W-1:0] r_lat, r_nx;
   logic [MOD_W-1:0] count_nx;
   logic [REP_W-1:0] rep_nx;
   logic             busy_nx, paused_nx, done_nx, err_nx;
   logic             last;

   // count sits on its final value; only meaningful while busy (m_lat >= 1 then)
   assign last = (count == (m_lat - MOD_ONE));

   // terminal count: an advancing cycle on which the counter wraps
   assign tc = busy & ~pause & ~stop & last;

   // State register and registered outputs; reset clears the latched run parameters too
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         count   <= '0;
         rep_cnt <= '0;
         m_lat   <= '0;
         r_lat   <= '0;
         busy    <= 1'b0;
         paused  <= 1'b0;
         done    <= 1'b0;
         err     <= 1'b0;
      end else begin
         state   <= state_nx;
         count   <= count_nx;
         rep_cnt <= rep_nx;
         m_lat   <= m_nx;
         r_lat   <= r_nx;
         busy    <= busy_nx;
         paused  <= paused_nx;
         done    <= done_nx;
         err     <= err_nx;
      end
   end

   // Next-state and next-output logic; stop outranks pause, pause outranks counting
   always_comb begin
      state_nx = state;
      count_nx = count;
      rep_nx   = rep_cnt;
      m_nx     = m_lat;
      r_nx     = r_lat;
      done_nx  = 1'b0;
      err_nx   = 1'b0;

      case (state)
         IDLE: begin
            if (start) begin
               if ((modulus != '0) && (reps != '0)) begin
                  m_nx     = modulus;
                  r_nx     = reps;
                  count_nx = '0;
                  rep_nx   = '0;
                  state_nx = RUN;
               end else begin
                  err_nx = 1'b1;
               end
            end
         end

         RUN, HOLD: begin
            if (stop) begin
               count_nx = '0;
               rep_nx   = '0;
               state_nx = IDLE;
            end else if (pause) begin
               state_nx = HOLD;
            end else begin
               state_nx = RUN;
               if (last) begin
                  count_nx = '0;
                  rep_nx   = rep_cnt + REP_ONE;
                  // final wrap of the run: rep_cnt lands on R, never past it
                  if (rep_cnt == (r_lat - REP_ONE)) begin
                     state_nx = DONE;
                     done_nx  = 1'b1;
                  end
               end else begin
                  count_nx = count + MOD_ONE;
               end
            end
         end

         DONE: begin
            state_nx = IDLE;
            if (stop) begin
               count_nx = '0;
               rep_nx   = '0;
            end
         end

         default: begin
            state_nx = IDLE;
            count_nx = '0;
            rep_nx   = '0;
         end
      endcase

      busy_nx   = (state_nx == RUN) || (state_nx == HOLD);
      paused_nx = (state_nx == HOLD);
   end

endmodule
